uart_stream_ctrl: RTL and testbench

- Host-side controller sitting directly upstream of the COREUART core.
- Converts a valid/ready byte stream into the core's CSN/WEN write strobes, gated by TXRDY.
- Drains received bytes from the core via CSN/OEN read strobes, gated by RXRDY, into a valid/ready output stream tagged with error flags.
- Keeps saturating error counters for system firmware.

---
 rtl/uart_stream_pkg.sv | 21 ++
 rtl/uart_sat_counter.sv | 25 ++
 rtl/uart_stream_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_uart_stream_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_stream_pkg.sv
// Shared encodings for the COREUART host-side stream controller.
package uart_stream_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WRITE  = 3'd1,
    TGUARD = 3'd2,
    READ   = 3'd3,
    RGUARD = 3'd4
  } state_e;

  typedef enum logic {
    GRANT_TX = 1'b0,
    GRANT_RX = 1'b1
  } grant_e;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_sat_counter.sv
// Saturating event counter with synchronous clear that overrides increment.
module uart_sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  // count register: clear wins, then increment until all-ones
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      count <= {WIDTH{1'b0}};
    end else if (clr) begin
      count <= {WIDTH{1'b0}};
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/uart_stream_ctrl.sv
// Bridges valid/ready byte streams to COREUART CSN/WEN/OEN strobes with
// round-robin TX/RX arbitration, guard intervals and saturating error counters.
module uart_stream_ctrl
  import uart_stream_pkg::*;
#(
  parameter int TX_GUARD = 3,
  parameter int RX_GUARD = 3,
  parameter int CNT_W    = 8
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [7:0]       rx_data,
  output logic             rx_perr,
  output logic             rx_ferr,
  output logic             rx_valid,
  input  logic             rx_ready,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] perr_cnt,
  output logic [CNT_W-1:0] ferr_cnt,
  output logic [CNT_W-1:0] ovf_cnt,
  output logic             CSN,
  output logic             WEN,
  output logic             OEN,
  output logic [7:0]       DATA_IN,
  input  logic             TXRDY,
  input  logic             RXRDY,
  input  logic [7:0]       DATA_OUT,
  input  logic             PARITY_ERR,
  input  logic             FRAMING_ERR,
  input  logic             OVERFLOW
);

  localparam int GUARD_MAX = int'(max2(TX_GUARD, RX_GUARD));
  localparam int GUARD_W   = (GUARD_MAX < 2) ? 1 : $clog2(GUARD_MAX);

  state_e             state_r;
  grant_e             last_grant_r;
  logic [GUARD_W-1:0] guard_cnt_r;
  logic               ovf_prev_r;
  logic               tx_elig_s;
  logic               rx_elig_s;
  logic               grant_tx_s;
  logic               grant_rx_s;
  logic               perr_inc_s;
  logic               ferr_inc_s;
  logic               ovf_inc_s;

  // arbiter: round-robin between TX and RX, only evaluated in IDLE and out of reset
  always_comb begin
    tx_elig_s  = tx_valid & TXRDY & RESET_N;
    rx_elig_s  = RXRDY & (~rx_valid | rx_ready) & RESET_N;
    grant_tx_s = 1'b0;
    grant_rx_s = 1'b0;
    if (state_r == IDLE) begin
      if (tx_elig_s && rx_elig_s) begin
        if (last_grant_r == GRANT_RX) begin
          grant_tx_s = 1'b1;
        end else begin
          grant_rx_s = 1'b1;
        end
      end else if (tx_elig_s) begin
        grant_tx_s = 1'b1;
      end else if (rx_elig_s) begin
        grant_rx_s = 1'b1;
      end else begin
        grant_tx_s = 1'b0;
        grant_rx_s = 1'b0;
      end
    end else begin
      grant_tx_s = 1'b0;
      grant_rx_s = 1'b0;
    end
  end

  assign tx_ready = grant_tx_s;

  // strobe FSM: strobes are set on entry to WRITE/READ so they come straight from flops
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r      <= IDLE;
      last_grant_r <= GRANT_RX;
      guard_cnt_r  <= {GUARD_W{1'b0}};
      CSN          <= 1'b1;
      WEN          <= 1'b1;
      OEN          <= 1'b1;
      DATA_IN      <= 8'h00;
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_tx_s) begin
            DATA_IN      <= tx_data;
            last_grant_r <= GRANT_TX;
            CSN          <= 1'b0;
            WEN          <= 1'b0;
            state_r      <= WRITE;
          end else if (grant_rx_s) begin
            last_grant_r <= GRANT_RX;
            CSN          <= 1'b0;
            OEN          <= 1'b0;
            state_r      <= READ;
          end else begin
            state_r <= IDLE;
          end
        end
        WRITE: begin
          CSN         <= 1'b1;
          WEN         <= 1'b1;
          guard_cnt_r <= {GUARD_W{1'b0}};
          state_r     <= TGUARD;
        end
        TGUARD: begin
          if (guard_cnt_r == GUARD_W'(TX_GUARD - 1)) begin
            state_r <= IDLE;
          end else begin
            guard_cnt_r <= guard_cnt_r + {{(GUARD_W-1){1'b0}}, 1'b1};
          end
        end
        READ: begin
          CSN         <= 1'b1;
          OEN         <= 1'b1;
          guard_cnt_r <= {GUARD_W{1'b0}};
          state_r     <= RGUARD;
        end
        RGUARD: begin
          if (guard_cnt_r == GUARD_W'(RX_GUARD - 1)) begin
            state_r <= IDLE;
          end else begin
            guard_cnt_r <= guard_cnt_r + {{(GUARD_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          CSN     <= 1'b1;
          WEN     <= 1'b1;
          OEN     <= 1'b1;
          state_r <= IDLE;
        end
      endcase
    end
  end

  // output stream: a capture on the READ closing edge takes priority over the accept
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rx_data  <= 8'h00;
      rx_perr  <= 1'b0;
      rx_ferr  <= 1'b0;
      rx_valid <= 1'b0;
    end else if (state_r == READ) begin
      rx_data  <= DATA_OUT;
      rx_perr  <= PARITY_ERR;
      rx_ferr  <= FRAMING_ERR;
      rx_valid <= 1'b1;
    end else if (rx_valid && rx_ready) begin
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= rx_valid;
    end
  end

  // previous OVERFLOW level for rising-edge detection
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ovf_prev_r <= 1'b0;
    end else begin
      ovf_prev_r <= OVERFLOW;
    end
  end

  assign perr_inc_s = (state_r == READ) & PARITY_ERR;
  assign ferr_inc_s = (state_r == READ) & FRAMING_ERR;
  assign ovf_inc_s  = OVERFLOW & ~ovf_prev_r;

  uart_sat_counter #(.WIDTH(CNT_W)) u_perr_cnt (
    .CLK(CLK), .RESET_N(RESET_N), .inc(perr_inc_s), .clr(clr_cnt), .count(perr_cnt)
  );

  uart_sat_counter #(.WIDTH(CNT_W)) u_ferr_cnt (
    .CLK(CLK), .RESET_N(RESET_N), .inc(ferr_inc_s), .clr(clr_cnt), .count(ferr_cnt)
  );

  uart_sat_counter #(.WIDTH(CNT_W)) u_ovf_cnt (
    .CLK(CLK), .RESET_N(RESET_N), .inc(ovf_inc_s), .clr(clr_cnt), .count(ovf_cnt)
  );

endmodule

// File: tb/tb_uart_stream_ctrl.sv
// Scoreboard bench for uart_stream_ctrl: directed stimulus feeds expected queues,
// a negedge monitor pops and compares core writes and the rx output stream.
module tb_uart_stream_ctrl;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic [7:0] tx_data = 8'hEE;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_perr, rx_ferr, rx_valid;
  logic       rx_ready = 1'b0;
  logic       clr_cnt = 1'b0;
  logic [7:0] perr_cnt, ferr_cnt, ovf_cnt;
  logic       CSN, WEN, OEN;
  logic [7:0] DATA_IN;
  logic       TXRDY = 1'b0;
  logic       RXRDY = 1'b0;
  logic [7:0] DATA_OUT = 8'h00;
  logic       PARITY_ERR = 1'b0;
  logic       FRAMING_ERR = 1'b0;
  logic       OVERFLOW = 1'b0;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } rx_item_t;

  logic [7:0] tx_stim_q[$];
  logic [7:0] tx_exp_q[$];
  rx_item_t   core_q[$];
  rx_item_t   rx_exp_q[$];
  int         grant_log[$];
  int         checks = 0;
  int         fails = 0;
  int         cyc = 0;
  int         n_wr = 0;
  int         n_rd = 0;
  int         last_strobe = -100;
  logic       tx_en = 1'b0;
  logic       rx_en = 1'b0;

  uart_stream_ctrl #(.TX_GUARD(3), .RX_GUARD(3), .CNT_W(8)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_perr(rx_perr), .rx_ferr(rx_ferr),
    .rx_valid(rx_valid), .rx_ready(rx_ready),
    .clr_cnt(clr_cnt), .perr_cnt(perr_cnt), .ferr_cnt(ferr_cnt), .ovf_cnt(ovf_cnt),
    .CSN(CSN), .WEN(WEN), .OEN(OEN), .DATA_IN(DATA_IN),
    .TXRDY(TXRDY), .RXRDY(RXRDY), .DATA_OUT(DATA_OUT),
    .PARITY_ERR(PARITY_ERR), .FRAMING_ERR(FRAMING_ERR), .OVERFLOW(OVERFLOW)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    fails++;
    $display("FAIL %s: event not expected / not seen (cycle %0d)", name, cyc);
  endtask

  task automatic push_tx(input logic [7:0] b);
    tx_stim_q.push_back(b);
    tx_exp_q.push_back(b);
  endtask

  task automatic push_rx(input logic [7:0] d, input logic pe, input logic fe);
    rx_item_t it;
    it.d  = d;
    it.pe = pe;
    it.fe = fe;
    core_q.push_back(it);
    rx_exp_q.push_back(it);
  endtask

  // Stream source and core model: sample handshakes at negedge, update after posedge
  initial begin : driver
    logic acc;
    logic rd;
    forever begin
      @(negedge CLK);
      acc = tx_valid & tx_ready;
      rd  = !CSN && !OEN;
      @(posedge CLK);
      #1;
      if (acc && tx_stim_q.size() > 0) void'(tx_stim_q.pop_front());
      if (rd && core_q.size() > 0) void'(core_q.pop_front());
      tx_valid = (tx_stim_q.size() > 0);
      tx_data  = (tx_stim_q.size() > 0) ? tx_stim_q[0] : 8'hEE;
      TXRDY    = tx_en;
      RXRDY    = rx_en && (core_q.size() > 0);
      if (core_q.size() > 0) begin
        DATA_OUT    = core_q[0].d;
        PARITY_ERR  = core_q[0].pe;
        FRAMING_ERR = core_q[0].fe;
      end
    end
  end

  // Monitor: strobe legality, core write data and rx stream against the scoreboard
  initial begin : monitor
    rx_item_t e;
    forever begin
      @(negedge CLK);
      if (RESET_N) begin
        if (!WEN && !OEN) fail_now("wen_oen_overlap");
        if (!CSN) begin
          check("strobe_spacing", 32'(cyc - last_strobe >= 4), 32'd1);
          last_strobe = cyc;
        end
        if (!CSN && !WEN) begin
          n_wr++;
          grant_log.push_back(0);
          if (tx_exp_q.size() == 0) fail_now("unexpected_write");
          else check("tx_data_in", 32'(DATA_IN), 32'(tx_exp_q.pop_front()));
        end
        if (!CSN && !OEN) begin
          n_rd++;
          grant_log.push_back(1);
        end
        if (rx_valid) begin
          if (rx_exp_q.size() == 0) fail_now("unexpected_rx_valid");
          else begin
            e = rx_exp_q[0];
            check("rx_data", 32'(rx_data), 32'(e.d));
            check("rx_perr", 32'(rx_perr), 32'(e.pe));
            check("rx_ferr", 32'(rx_ferr), 32'(e.fe));
            if (rx_ready) void'(rx_exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int t;
    int c_r;
    int c_v;
    int nrdy;
    int rd0;
    int wr0;
    int exp_grants[4];

    // Reset values
    repeat (3) @(posedge CLK);
    #1;
    check("rst_csn", 32'(CSN), 32'd1);
    check("rst_wen", 32'(WEN), 32'd1);
    check("rst_oen", 32'(OEN), 32'd1);
    check("rst_data_in", 32'(DATA_IN), 32'd0);
    check("rst_tx_ready", 32'(tx_ready), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_data", 32'({rx_data, rx_perr, rx_ferr}), 32'd0);
    check("rst_counters", 32'({perr_cnt, ferr_cnt, ovf_cnt}), 32'd0);
    @(negedge CLK);
    RESET_N = 1'b1;
    repeat (4) @(posedge CLK);
    #1;

    // 1: single TX byte
    tx_en = 1'b1;
    push_tx(8'hA5);
    nrdy = 0;
    repeat (12) begin
      @(negedge CLK);
      if (tx_ready) nrdy++;
    end
    check("tx_ready_pulse_count", 32'(nrdy), 32'd1);
    check("tx_write_count", 32'(n_wr), 32'd1);

    // 3: both sides eligible together -> RX, TX, RX, TX
    @(posedge CLK); #1;
    rx_ready = 1'b1;
    @(posedge CLK); #1;
    grant_log.delete();
    push_tx(8'h11);
    push_tx(8'h22);
    push_rx(8'h81, 1'b0, 1'b0);
    push_rx(8'h82, 1'b0, 1'b0);
    rx_en = 1'b1;
    for (t = 0; t < 80 && grant_log.size() < 4; t++) @(negedge CLK);
    if (grant_log.size() < 4) fail_now("rr_timeout");
    else begin
      exp_grants = '{1, 0, 1, 0};
      for (int i = 0; i < 4; i++) check($sformatf("rr_grant_%0d", i), 32'(grant_log[i]), 32'(exp_grants[i]));
    end
    for (t = 0; t < 40 && rx_exp_q.size() > 0; t++) @(negedge CLK);
    repeat (6) @(negedge CLK);

    // 2: RX latency from RXRDY seen in IDLE to rx_valid
    @(posedge CLK); #1;
    push_rx(8'h3C, 1'b0, 1'b1);
    c_r = -1;
    c_v = -1;
    for (t = 0; t < 20 && c_v < 0; t++) begin
      @(negedge CLK);
      if (RXRDY && c_r < 0) c_r = cyc;
      if (rx_valid && c_v < 0) c_v = cyc;
    end
    if (c_v < 0 || c_r < 0) fail_now("rx_latency_timeout");
    else check("rx_latency", 32'(c_v - c_r), 32'd2);
    repeat (6) @(negedge CLK);

    // 4: held output blocks further reads
    @(posedge CLK); #1;
    rx_ready = 1'b0;
    rd0 = n_rd;
    push_rx(8'h44, 1'b0, 1'b0);
    push_rx(8'h55, 1'b1, 1'b0);
    for (t = 0; t < 20 && !rx_valid; t++) @(negedge CLK);
    if (!rx_valid) fail_now("hold_valid_timeout");
    repeat (20) @(negedge CLK);
    check("hold_read_count", 32'(n_rd - rd0), 32'd1);
    check("hold_rx_data", 32'(rx_data), 32'h44);
    @(posedge CLK); #1;
    rx_ready = 1'b1;
    for (t = 0; t < 40 && rx_exp_q.size() > 0; t++) @(negedge CLK);
    check("release_read_count", 32'(n_rd - rd0), 32'd2);
    check("release_drained", 32'(rx_exp_q.size()), 32'd0);

    // Overflow rising edges: a level held high counts once
    @(posedge CLK); #1;
    OVERFLOW = 1'b1;
    repeat (3) @(posedge CLK); #1;
    OVERFLOW = 1'b0;
    repeat (2) @(posedge CLK); #1;
    OVERFLOW = 1'b1;
    @(posedge CLK); #1;
    OVERFLOW = 1'b0;
    @(negedge CLK);
    check("ovf_cnt", 32'(ovf_cnt), 32'd2);
    check("ferr_cnt", 32'(ferr_cnt), 32'd1);
    check("perr_cnt_before_sat", 32'(perr_cnt), 32'd1);

    // 5: 300 parity-error reads saturate, then clear beats a same-cycle increment
    @(posedge CLK); #1;
    for (int i = 0; i < 300; i++) push_rx(8'(i), 1'b1, 1'b0);
    for (t = 0; t < 3000 && rx_exp_q.size() > 0; t++) @(negedge CLK);
    if (rx_exp_q.size() > 0) fail_now("sat_drain_timeout");
    check("perr_cnt_saturated", 32'(perr_cnt), 32'd255);
    @(posedge CLK); #1;
    push_rx(8'h99, 1'b1, 1'b1);
    for (t = 0; t < 20 && OEN; t++) @(negedge CLK);
    if (OEN) fail_now("clr_read_timeout");
    clr_cnt = 1'b1;
    @(posedge CLK); #1;
    clr_cnt = 1'b0;
    @(negedge CLK);
    check("perr_cnt_cleared", 32'(perr_cnt), 32'd0);
    check("ferr_cnt_cleared", 32'(ferr_cnt), 32'd0);
    check("ovf_cnt_cleared", 32'(ovf_cnt), 32'd0);
    repeat (8) @(negedge CLK);

    // 6: reset asserted in the WRITE cycle
    @(posedge CLK); #1;
    push_tx(8'h5A);
    for (t = 0; t < 20 && !(!CSN && !WEN); t++) @(negedge CLK);
    if (CSN || WEN) fail_now("rst_write_timeout");
    #2;
    wr0 = n_wr;
    RESET_N = 1'b0;
    #1;
    check("async_rst_csn", 32'(CSN), 32'd1);
    check("async_rst_wen", 32'(WEN), 32'd1);
    repeat (3) @(posedge CLK);
    #1;
    RESET_N = 1'b1;
    repeat (20) @(negedge CLK);
    check("no_replay", 32'(n_wr - wr0), 32'd0);
    @(posedge CLK); #1;
    push_tx(8'hC3);
    for (t = 0; t < 20 && tx_exp_q.size() > 0; t++) @(negedge CLK);
    check("post_reset_write", 32'(n_wr - wr0), 32'd1);
    check("tx_queue_empty", 32'(tx_exp_q.size()), 32'd0);

    repeat (5) @(negedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
